// File: rtl/wb_master_seq.sv
// rtl/wb_master_seq.sv - Wishbone classic-cycle traffic master with read-back compare
module wb_master_seq #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    COUNT      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ADDR_STEP  = DATA_WIDTH / 8,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000,
  parameter int                    MODE       = 0,
  parameter int                    IDLE_GAP   = 0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  output logic                             cyc_o,
  output logic                             stb_o,
  output logic                             we_o,
  output logic [ADDR_WIDTH-1:0]            adr_o,
  output logic [DATA_WIDTH/8-1:0]          sel_o,
  output logic [DATA_WIDTH-1:0]            dat_o,
  input  logic [DATA_WIDTH-1:0]            dat_i,
  input  logic                             ack_i,
  input  logic                             err_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [$clog2(COUNT+1)-1:0]       err_cnt_o,
  output logic [$clog2(COUNT+1)-1:0]       mismatch_cnt_o
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] LAST    = CW'(COUNT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(COUNT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       k, k_n;
  logic [TW-1:0]       wait_cnt, wait_n;
  logic [GW-1:0]       gap_cnt, gap_n;
  logic [CW-1:0]       err_n, mis_n;
  logic                cyc_n, stb_n, we_n, busy_n, done_n;
  logic [ADDR_WIDTH-1:0] adr_n;
  logic [SW-1:0]       sel_n;
  logic [DATA_WIDTH-1:0] dat_n;

  logic [CW-1:0]       ld_idx, ld_pair;
  logic                ld_we;
  logic [ADDR_WIDTH-1:0] ld_adr;
  logic [DATA_WIDTH-1:0] ld_dat;
  logic                to_hit;
  logic [DATA_WIDTH-1:0] expect_dat;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [CW-1:0] j);
    return DATA_WIDTH'(SEED) + DATA_WIDTH'(j);
  endfunction

  // Slot to be presented on the bus next: slot 0 from IDLE, the pending slot
  // after a gap, or the following slot when running back-to-back.
  always_comb begin
    if (state == S_IDLE)     ld_idx = '0;
    else if (state == S_GAP) ld_idx = k;
    else                     ld_idx = k + CW'(1);
    ld_pair = (MODE == 2) ? (ld_idx >> 1) : ld_idx;
    ld_we   = (MODE == 0) || ((MODE == 2) && !ld_idx[0]);
    ld_adr  = BASE_ADDR + ADDR_WIDTH'(ld_pair) * ADDR_WIDTH'(ADDR_STEP);
    ld_dat  = ld_we ? pattern(ld_pair) : '0;
  end

  assign to_hit     = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT));
  assign expect_dat = pattern(k >> 1);

  always_comb begin
    state_n = state;
    k_n     = k;
    wait_n  = wait_cnt;
    gap_n   = gap_cnt;
    err_n   = err_cnt_o;
    mis_n   = mismatch_cnt_o;
    cyc_n   = cyc_o;
    stb_n   = stb_o;
    we_n    = we_o;
    adr_n   = adr_o;
    sel_n   = sel_o;
    dat_n   = dat_o;
    busy_n  = busy_o;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_REQ;
          k_n     = '0;
          wait_n  = '0;
          err_n   = '0;
          mis_n   = '0;
          busy_n  = 1'b1;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          sel_n   = '1;
          we_n    = ld_we;
          adr_n   = ld_adr;
          dat_n   = ld_dat;
        end
      end
      S_REQ: begin
        if (stb_o && (err_i || ack_i || to_hit)) begin
          // err_i wins over a simultaneous ack_i; a timeout counts as an error
          if (err_i || !ack_i) begin
            if (err_cnt_o != CNT_MAX) err_n = err_cnt_o + CW'(1);
          end else if ((MODE == 2) && k[0] && !we_o && (dat_i != expect_dat)) begin
            if (mismatch_cnt_o != CNT_MAX) mis_n = mismatch_cnt_o + CW'(1);
          end
          wait_n = '0;
          if (k == LAST) begin
            state_n = S_DONE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
            adr_n   = '0;
            sel_n   = '0;
            dat_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (IDLE_GAP == 0) begin
            k_n   = k + CW'(1);
            we_n  = ld_we;
            adr_n = ld_adr;
            dat_n = ld_dat;
          end else begin
            state_n = S_GAP;
            k_n     = k + CW'(1);
            gap_n   = '0;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
            adr_n   = '0;
            sel_n   = '0;
            dat_n   = '0;
          end
        end else if (TIMEOUT != 0) begin
          wait_n = wait_cnt + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(IDLE_GAP - 1)) begin
          state_n = S_REQ;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          sel_n   = '1;
          we_n    = ld_we;
          adr_n   = ld_adr;
          dat_n   = ld_dat;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      k              <= '0;
      wait_cnt       <= '0;
      gap_cnt        <= '0;
      err_cnt_o      <= '0;
      mismatch_cnt_o <= '0;
      cyc_o          <= 1'b0;
      stb_o          <= 1'b0;
      we_o           <= 1'b0;
      adr_o          <= '0;
      sel_o          <= '0;
      dat_o          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state          <= state_n;
      k              <= k_n;
      wait_cnt       <= wait_n;
      gap_cnt        <= gap_n;
      err_cnt_o      <= err_n;
      mismatch_cnt_o <= mis_n;
      cyc_o          <= cyc_n;
      stb_o          <= stb_n;
      we_o           <= we_n;
      adr_o          <= adr_n;
      sel_o          <= sel_n;
      dat_o          <= dat_n;
      busy_o         <= busy_n;
      done_o         <= done_n;
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// tb/tb_wb_master_seq.sv - directed bench for wb_master_seq (write burst, read-back, gaps, timeout, reset)
module tb_wb_master_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: write-only, back-to-back, 15-cycle timeout
  logic        a_start, a_cyc, a_stb, a_we, a_ack, a_err, a_busy, a_done, a_resp;
  logic [31:0] a_adr, a_dat_o, a_dat_i;
  logic [3:0]  a_sel;
  logic [2:0]  a_errc, a_misc;

  assign a_ack   = a_stb & a_resp;
  assign a_err   = 1'b0;
  assign a_dat_i = 32'h0;

  wb_master_seq #(.COUNT(4), .MODE(0), .IDLE_GAP(0), .TIMEOUT(15)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start),
    .cyc_o(a_cyc), .stb_o(a_stb), .we_o(a_we), .adr_o(a_adr), .sel_o(a_sel),
    .dat_o(a_dat_o), .dat_i(a_dat_i), .ack_i(a_ack), .err_i(a_err),
    .busy_o(a_busy), .done_o(a_done), .err_cnt_o(a_errc), .mismatch_cnt_o(a_misc)
  );

  // Instance B: write/read-back pairs with a 2-cycle idle gap
  logic        b_start, b_cyc, b_stb, b_we, b_ack, b_err, b_busy, b_done;
  logic [31:0] b_adr, b_dat_o, b_dat_i;
  logic [3:0]  b_sel;
  logic [2:0]  b_errc, b_misc;
  logic [3:0]  b_ws, wcnt;
  logic        b_corrupt, b_inj;
  logic [31:0] mem [0:3];

  assign b_ack   = b_stb && (wcnt == b_ws);
  assign b_err   = b_ack && b_inj && !b_we && (b_adr == 32'h0);
  assign b_dat_i = (b_corrupt && b_adr == 32'h4) ? 32'h0 : mem[b_adr[3:2]];

  always_ff @(posedge clk) begin
    if (!b_stb || b_ack) wcnt <= 4'd0;
    else                 wcnt <= wcnt + 4'd1;
    if (b_stb && b_we && b_ack && !b_err) mem[b_adr[3:2]] <= b_dat_o;
  end

  wb_master_seq #(.COUNT(4), .MODE(2), .IDLE_GAP(2), .TIMEOUT(15)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start),
    .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we), .adr_o(b_adr), .sel_o(b_sel),
    .dat_o(b_dat_o), .dat_i(b_dat_i), .ack_i(b_ack), .err_i(b_err),
    .busy_o(b_busy), .done_o(b_done), .err_cnt_o(b_errc), .mismatch_cnt_o(b_misc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one B sequence, measuring idle-gap lengths and strobe hold lengths.
  task automatic run_b(output int cnt, output int ngap, output int nbad,
                       output int smin, output int smax);
    int lowrun, srun;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 1; lowrun = 0; srun = 0; ngap = 0; nbad = 0; smin = 1000; smax = 0;
    while (cnt < 200) begin
      if (b_busy && !b_cyc) lowrun++;
      else if (b_cyc && lowrun > 0) begin
        ngap++;
        if (lowrun != 2) nbad++;
        lowrun = 0;
      end
      if (b_stb) srun++;
      else if (srun > 0) begin
        if (srun < smin) smin = srun;
        if (srun > smax) smax = srun;
        srun = 0;
      end
      if (b_done) break;
      tick();
      cnt++;
    end
  endtask

  initial begin
    int cnt, n0, ngap, nbad, smin, smax, saw;
    a_start = 1'b0; a_resp = 1'b1;
    b_start = 1'b0; b_ws = 4'd0; b_corrupt = 1'b0; b_inj = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_cyc_stb", {a_cyc, a_stb, a_we}, 3'b000);
    check("rst_adr_dat", {a_adr, a_dat_o}, 64'h0);
    check("rst_sel", {a_sel, b_sel}, 8'h00);
    check("rst_status", {a_busy, a_done, a_errc, a_misc}, 8'h00);
    rst = 1'b0;
    tick();

    // Write burst, zero-wait slave, extra start pulse while busy
    a_resp = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_adr_%0d", k), a_adr, 32'(k * 4));
      check($sformatf("wr_dat_%0d", k), a_dat_o, 32'hA5A5_0000 + 32'(k));
      check($sformatf("wr_ctl_%0d", k), {a_cyc, a_stb, a_we, a_sel, a_busy}, 8'b1111_1111);
      a_start = (k == 1);
      tick();
    end
    a_start = 1'b0;
    check("wr_done", {a_done, a_busy, a_cyc, a_stb}, 4'b1000);
    check("wr_errc", a_errc, 3'd0);
    tick();
    check("wr_done_pulse", {a_done, a_busy}, 2'b00);

    // Timeout: slave never answers
    a_resp = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    cnt = 1; n0 = 0;
    while (!a_done && cnt < 200) begin
      if (a_stb && a_adr == 32'h0) n0++;
      tick();
      cnt++;
    end
    check("to_cycles", cnt, 65);
    check("to_slot0_hold", n0, 16);
    check("to_errc", a_errc, 3'd4);
    check("to_done_busy", {a_done, a_busy}, 2'b10);
    tick();

    // Read-back compare, address 0x4 corrupted on read
    b_ws = 4'd0; b_corrupt = 1'b1; b_inj = 1'b0;
    run_b(cnt, ngap, nbad, smin, smax);
    check("rb_cycles", cnt, 11);
    check("rb_misc", b_misc, 3'd1);
    check("rb_errc", b_errc, 3'd0);
    check("rb_gaps", {ngap[7:0], nbad[7:0]}, 16'h0300);
    tick();
    check("rb_counts_hold", {b_misc, b_errc}, 6'b001_000);

    // Wait states, idle gaps, err_i together with ack_i on a read
    b_ws = 4'd3; b_corrupt = 1'b0; b_inj = 1'b1;
    run_b(cnt, ngap, nbad, smin, smax);
    check("ws_cycles", cnt, 23);
    check("ws_errc", b_errc, 3'd1);
    check("ws_misc", b_misc, 3'd0);
    check("ws_gaps", {ngap[7:0], nbad[7:0]}, 16'h0300);
    check("ws_stb_hold", {smin[7:0], smax[7:0]}, 16'h0404);
    b_inj = 1'b0;
    tick();

    // Reset in the middle of slot 1
    a_resp = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (18) tick();
    check("mid_errc", a_errc, 3'd1);
    check("mid_adr", a_adr, 32'h4);
    rst = 1'b1;
    tick();
    check("rst_mid_bus", {a_cyc, a_stb, a_we, a_sel}, 7'b0);
    check("rst_mid_status", {a_busy, a_done, a_errc, a_misc}, 8'h00);
    check("rst_mid_adr", a_adr, 32'h0);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_done || a_cyc || a_busy) saw++;
    end
    check("rst_no_done", saw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
